// File: rtl/tx_crc_frame_ctrl.sv
// tx_crc_frame_ctrl
//   Frames a 20-bit TX payload stream for the SerDes TX path. Each frame is
//   1..FRAME_WORDS payload words followed by one trailer word
//   {TRAILER_TAG, crc}. The CRC-10 itself lives in an external 20-bit
//   parallel engine; this block sequences it (clear, enable, data).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   tx_en               permits a new frame to start (sampled at frame start only)
//   s_valid/s_ready     payload handshake, s_data word, s_last ends the frame
//   m_valid/m_ready     output handshake, m_data word, m_last marks the trailer
//   crc_en, crc_data    engine enable/data (combinational from the accept)
//   crc_clr_n           registered active-low engine clear
//   crc_in              engine result, registered inside the engine
//   frame_cnt           trailers emitted, wraps silently
module tx_crc_frame_ctrl #(
    parameter int         FRAME_WORDS = 16,
    parameter logic [9:0] TRAILER_TAG = 10'h3A5,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             s_valid,
    input  logic [19:0]      s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             m_valid,
    output logic [19:0]      m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             crc_en,
    output logic [19:0]      crc_data,
    output logic             crc_clr_n,
    input  logic [9:0]       crc_in,
    output logic [CNT_W-1:0] frame_cnt
);

    // wcnt only has to reach FRAME_WORDS-1; keep at least one bit.
    localparam int WCNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic              slot_free;
    logic              accept;
    logic              frame_end;

    // Single output register: it can take a new word when empty or draining.
    assign slot_free = !m_valid || m_ready;

    // tx_en gates only the first word; once wcnt has moved the frame runs out.
    assign s_ready   = (state == PAYLOAD) && slot_free && ((wcnt != '0) || tx_en);
    assign accept    = s_valid && s_ready;
    assign frame_end = s_last || (wcnt == WCNT_MAX);

    // The engine sees every word; it only samples while crc_en is high.
    assign crc_en    = accept;
    assign crc_data  = s_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            wcnt      <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
            frame_cnt <= '0;
            crc_clr_n <= 1'b0;
        end else begin
            // Drain by default; a load below overrides.
            if (m_ready) m_valid <= 1'b0;

            case (state)
                CLEAR: begin
                    // One cycle with the engine held in clear.
                    crc_clr_n <= 1'b1;
                    state     <= PAYLOAD;
                end

                PAYLOAD: begin
                    if (accept) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                        if (frame_end) begin
                            wcnt  <= '0;
                            state <= TRAILER;
                        end else begin
                            wcnt  <= wcnt + 1'b1;
                        end
                    end
                end

                TRAILER: begin
                    // crc_in already includes the last word (registered on
                    // its accept edge) and is frozen since crc_en is low.
                    if (slot_free) begin
                        m_data    <= {TRAILER_TAG, crc_in};
                        m_valid   <= 1'b1;
                        m_last    <= 1'b1;
                        frame_cnt <= frame_cnt + 1'b1;
                        crc_clr_n <= 1'b0;
                        state     <= CLEAR;
                    end
                end

                default: begin
                    crc_clr_n <= 1'b0;
                    state     <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_crc_frame_ctrl.sv
// Bench for tx_crc_frame_ctrl: stub CRC-10 engine, a frame-level scoreboard
// checked every cycle, and directed scenarios with literal trailer values.
module tb_tx_crc_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst, tx_en, s_valid, s_last, m_ready;
    logic [19:0] s_data;
    logic        s_ready, m_valid, m_last, crc_en, crc_clr_n;
    logic [19:0] m_data, crc_data;
    logic [9:0]  crc_q;
    logic [15:0] frame_cnt;

    tx_crc_frame_ctrl dut (
        .clk(clk), .rst(rst), .tx_en(tx_en),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .crc_en(crc_en), .crc_data(crc_data), .crc_clr_n(crc_clr_n),
        .crc_in(crc_q), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // CRC-10, poly x^10+x^9+x^5+x^4+x+1, MSB-first over the 20-bit word.
    function automatic logic [9:0] crc_word(input logic [9:0] c, input logic [19:0] d);
        logic fb;
        for (int i = 19; i >= 0; i--) begin
            fb = c[9] ^ d[i];
            c  = {c[8:0], 1'b0};
            if (fb) c = c ^ 10'h233;
        end
        return c;
    endfunction

    // External engine stand-in: async active-low clear, registered result.
    always @(posedge clk or negedge crc_clr_n) begin
        if (!crc_clr_n)  crc_q <= 10'h0;
        else if (crc_en) crc_q <= crc_word(crc_q, crc_data);
    end

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [19:0] d; logic l; } exp_t;
    exp_t        expq[$];
    logic [19:0] cur[$];
    int          trl_done = 0;
    int          clr_run = 0;
    logic        prev_hold = 1'b0;
    logic [19:0] prev_data;
    logic        prev_last;
    logic [19:0] last_trailer = '0;

    always @(negedge clk) begin
        exp_t        e;
        logic [9:0]  c;
        if (rst) begin
            expq.delete();
            cur.delete();
            trl_done  = 0;
            clr_run   = 0;
            prev_hold = 1'b0;
        end else begin
            chk("crc_en", crc_en, s_valid && s_ready);
            chk("crc_data", crc_data, s_data);
            chk("frame_cnt", frame_cnt, 32'(trl_done + ((m_valid && m_last) ? 1 : 0)));
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid && !m_ready) chk("s_ready_stall", s_ready, 1'b0);
            if (cur.size() == 0 && !tx_en) chk("s_ready_txen", s_ready, 1'b0);
            if (m_valid && m_last && !prev_hold) chk("clr_with_trailer", crc_clr_n, 1'b0);
            if (!crc_clr_n) clr_run++;
            else begin
                if (clr_run != 0) chk("clr_width", clr_run, 1);
                clr_run = 0;
            end
            if (m_valid && m_ready) begin
                chk("exp_queue_nonempty", expq.size() != 0, 1'b1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_last", m_last, e.l);
                end
                if (m_last) begin
                    trl_done++;
                    last_trailer = m_data;
                end
            end
            if (s_valid && s_ready) begin
                cur.push_back(s_data);
                e.d = s_data; e.l = 1'b0;
                expq.push_back(e);
                if (s_last || cur.size() == 16) begin
                    c = 10'h0;
                    foreach (cur[i]) c = crc_word(c, cur[i]);
                    e.d = {10'h3A5, c}; e.l = 1'b1;
                    expq.push_back(e);
                    cur.delete();
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [19:0] d, input logic l);
        int   t = 0;
        logic ok = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!ok && t < 300) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk); #1;
            t++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("send_accepted", ok, 1'b1);
    endtask

    task automatic wait_trl(input int target);
        int t = 0;
        while (trl_done < target && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("trailer_seen", trl_done >= target, 1'b1);
    endtask

    int          gaps;
    logic [19:0] t_ref;
    int          sizes[4] = '{3, 16, 1, 5};

    initial begin
        rst = 1'b1; tx_en = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        s_data = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, 20'h0);
        chk("rst_frame_cnt", frame_cnt, 16'h0);
        chk("rst_crc_clr_n", crc_clr_n, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // Full-length frame of zeros.
        for (int i = 0; i < 16; i++) send(20'h0, 1'b0);
        wait_trl(1);
        chk("t1_trailer", last_trailer, 20'hE9400);
        chk("t1_frame_cnt", frame_cnt, 16'd1);

        // Single-word frame.
        send(20'h00001, 1'b1);
        wait_trl(2);
        chk("t2_trailer", last_trailer, 20'hE9633);

        // Same frame unstalled, then stalled on word 3 and on the trailer.
        for (int i = 0; i < 6; i++) send(20'h11111 * (i + 1), i == 5);
        wait_trl(3);
        t_ref = last_trailer;
        for (int i = 0; i < 6; i++) begin
            send(20'h11111 * (i + 1), i == 5);
            if (i == 2) begin
                m_ready = 1'b0;
                fork begin repeat (5) @(posedge clk); #1 m_ready = 1'b1; end join_none
            end
        end
        @(posedge clk); #1 m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b1;
        wait_trl(4);
        chk("t3_stall_trailer", last_trailer, t_ref);

        // tx_en low at frame start blocks; dropped mid-frame does not.
        tx_en = 1'b0; s_valid = 1'b1; s_data = 20'hABCDE;
        repeat (5) begin
            @(negedge clk);
            chk("t4_blocked_ready", s_ready, 1'b0);
            chk("t4_blocked_crc_en", crc_en, 1'b0);
        end
        @(posedge clk); #1 s_valid = 1'b0; tx_en = 1'b1;
        send(20'h12345, 1'b0);
        send(20'h6789A, 1'b0);
        tx_en = 1'b0;
        send(20'hBCDEF, 1'b0);
        send(20'h0F0F0, 1'b0);
        send(20'hF0F0F, 1'b1);
        wait_trl(5);
        chk("t4_frame_cnt", frame_cnt, 16'd5);
        tx_en = 1'b1;

        // Reset on word 7 of a frame.
        for (int i = 0; i < 6; i++) send(20'h55555 ^ 20'(i), 1'b0);
        s_valid = 1'b1; s_data = 20'h77777; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t5_m_valid", m_valid, 1'b0);
        chk("t5_crc_clr_n", crc_clr_n, 1'b0);
        @(posedge clk); #1 rst = 1'b0; s_valid = 1'b0;
        send(20'h00001, 1'b1);
        wait_trl(1);
        chk("t5_trailer", last_trailer, 20'hE9633);
        chk("t5_frame_cnt", frame_cnt, 16'd1);

        // Back-to-back frames, continuous s_valid: one dead output cycle per frame.
        gaps = 0;
        fork
            begin
                for (int f = 0; f < 4; f++)
                    for (int w = 0; w < sizes[f]; w++)
                        send(20'($urandom), (w == sizes[f] - 1) && (sizes[f] != 16));
            end
            begin
                int t = 0;
                while (!m_valid && t < 50) begin @(posedge clk); #1; t++; end
                while (trl_done < 5 && t < 1000) begin
                    @(posedge clk); #1; t++;
                    if (!m_valid) gaps++;
                end
            end
        join
        chk("t6_trailers", trl_done, 5);
        chk("t6_dead_cycles", gaps, 4);
        chk("t6_frame_cnt", frame_cnt, 16'd5);
        repeat (3) @(posedge clk);
        chk("queue_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
